// File: rtl/vend_sequencer.sv
// Soda vending sequencer: coin edge capture, priority credit accumulation, vend and nickel-change handshakes.
// Latency: coin edge -> credit 2 cycles; credit>=PRICE -> o_soda_req 1 cycle. Reqs held until ack; optional i_cancel via VEND_CANCEL_EN.
module vend_sequencer #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_nickle,
    input  logic                i_dime,
    input  logic                i_quarter,
`ifdef VEND_CANCEL_EN
    input  logic                i_cancel,
`endif
    input  logic                i_soda_ack,
    input  logic                i_change_ack,
    output logic                o_soda_req,
    output logic                o_change_req,
    output logic                o_soda,
    output logic [2:0]          o_change,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_coin_reject,
    output logic                o_busy
);
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] coin_val;
    logic [2:0]          coin_lvl, coin_q, coin_edge;
    logic [2:0]          pend_q, pend_d, take;
    logic [2:0]          remain_q, remain_d;
    logic [2:0]          change_q, change_d;
    logic                soda_q, soda_d;
    logic                gap_q, gap_d;
    logic                reject_q, reject_d;
    logic                cancel;

`ifdef VEND_CANCEL_EN
    assign cancel = i_cancel;
`else
    assign cancel = 1'b0;
`endif

    // Bit order {quarter, dime, nickel}; edges are taken against last cycle's level.
    assign coin_lvl  = {i_quarter, i_dime, i_nickle};
    assign coin_edge = coin_lvl & ~coin_q;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        remain_d = remain_q;
        change_d = change_q;
        soda_d   = 1'b0;
        gap_d    = 1'b0;
        take     = 3'b000;
        coin_val = '0;
        case (state_q)
            COLLECT: begin
                if (credit_q >= PRICE_C) begin
                    state_d = VEND;
                end else if (cancel && credit_q != '0) begin
                    remain_d = 3'(credit_q);
                    change_d = 3'(credit_q);
                    credit_d = '0;
                    state_d  = CHANGE;
                end else if (pend_q[2]) begin
                    take     = 3'b100;
                    coin_val = CREDIT_W'(5);
                end else if (pend_q[1]) begin
                    take     = 3'b010;
                    coin_val = CREDIT_W'(2);
                end else if (pend_q[0]) begin
                    take     = 3'b001;
                    coin_val = CREDIT_W'(1);
                end
                credit_d = (take != 3'b000) ? credit_q + coin_val : credit_d;
            end
            VEND: begin
                if (i_soda_ack) begin
                    soda_d   = 1'b1;
                    change_d = 3'(credit_q - PRICE_C);
                    remain_d = 3'(credit_q - PRICE_C);
                    credit_d = '0;
                    state_d  = (credit_q == PRICE_C) ? COLLECT : CHANGE;
                end
            end
            CHANGE: begin
                // The hopper needs a dead cycle after each ack before the next request.
                if (!gap_q && i_change_ack) begin
                    remain_d = remain_q - 3'd1;
                    gap_d    = 1'b1;
                    if (remain_q == 3'd1) state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        // A coin consumed this cycle frees its slot, so a coincident edge is accepted.
        pend_d   = (pend_q & ~take) | coin_edge;
        reject_d = |(coin_edge & pend_q & ~take);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            coin_q   <= 3'b000;
            pend_q   <= 3'b000;
            remain_q <= 3'd0;
            change_q <= 3'd0;
            soda_q   <= 1'b0;
            gap_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            coin_q   <= coin_lvl;
            pend_q   <= pend_d;
            remain_q <= remain_d;
            change_q <= change_d;
            soda_q   <= soda_d;
            gap_q    <= gap_d;
            reject_q <= reject_d;
        end
    end

    assign o_soda_req    = (state_q == VEND);
    assign o_change_req  = (state_q == CHANGE) && !gap_q;
    assign o_soda        = soda_q;
    assign o_change      = change_q;
    assign o_credit      = credit_q;
    assign o_coin_reject = reject_q;
    assign o_busy        = (state_q != COLLECT);
endmodule
